// File: rtl/uart_tx_gen2_pkg.sv
// Shared types and constants for the second-generation UART transmitter.
//   tx_state_e : transmitter FSM state encoding
//   MIN_DATA_W / MAX_DATA_W : legal range of data bits per frame
//   parity_bit() : parity of a data word, even (odd=0) or odd (odd=1)
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned MIN_DATA_W = 5;
    localparam int unsigned MAX_DATA_W = 9;

    // Callers zero-extend narrower words; zero padding does not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_gen2_if.sv
// Host-side write handshake of the UART transmitter.
//   P_DATA     : parallel word to transmit (host -> TX)
//   DATA_VALID : P_DATA valid (host -> TX)
//   DATA_READY : input FIFO not full (TX -> host)
// A word is written on a clock edge where DATA_VALID & DATA_READY.
interface uart_tx_gen2_if #(
    parameter int unsigned DATA_W = 8
);

    logic [DATA_W-1:0] P_DATA;
    logic              DATA_VALID;
    logic              DATA_READY;

    modport master (
        output P_DATA,
        output DATA_VALID,
        input  DATA_READY
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        output DATA_READY
    );

endinterface

// File: rtl/uart_tx_gen2_fifo.sv
// Synchronous FIFO buffering host words ahead of the serialiser.
//   clk, reset : clock and asynchronous active-low reset (flushes the FIFO)
//   push, wdata: write request and data; ignored while full
//   pop, rdata : read request; rdata shows the head word (valid when !empty)
//   full, empty, level : occupancy, all derived from registered state only
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is not reset: pointer/level reset is what flushes the FIFO.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_tx_gen2.sv
// Second-generation UART transmitter: start bit, LSB-first data, optional
// parity, one or two stop bits, with a FIFO input buffer and back-to-back
// frames (no idle bit when another word is queued).
//   clk, reset : clock and asynchronous active-low reset
//   host       : P_DATA / DATA_VALID / DATA_READY write handshake
//   PAR_EN     : insert parity bit;  PAR_TYP : 0 even, 1 odd
//   STOP2      : two stop bits when set
//   PRESCALE   : clocks per bit minus one
//   TX_OUT     : registered serial line, idles high
//   Busy       : FSM not idle
//   FIFO_LEVEL : words currently buffered
// Frame settings are captured when a word is popped, so mid-frame changes
// only affect later frames.
module uart_tx_gen2
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_gen2_if.slave                 host,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    input  logic [PRESCALE_W-1:0]         PRESCALE,
    output logic                          TX_OUT,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] baud_q,  baud_d;
    logic [CNT_W-1:0]      bit_q,   bit_d;
    logic                  stop_q,  stop_d;
    logic [DATA_W-1:0]     data_q,  data_d;
    logic                  par_q,   par_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q,  stop2_d;
    logic [PRESCALE_W-1:0] presc_q,  presc_d;
    logic                  tx_q,     tx_d;

    logic                  load;
    logic                  pop;
    logic                  bit_end;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_W-1:0]     fifo_rdata;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (host.DATA_VALID),
        .pop   (pop),
        .wdata (host.P_DATA),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

    assign host.DATA_READY = !fifo_full;
    assign bit_end         = (baud_q == presc_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            data_q   <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            presc_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            data_q   <= data_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            presc_q  <= presc_d;
            tx_q     <= tx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        data_d   = data_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        presc_d  = presc_q;
        load     = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + PRESCALE_W'(1);
        end

        case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame start, from IDLE or straight out of the last stop bit.
        if (load) begin
            state_d  = START;
            baud_d   = '0;
            data_d   = fifo_rdata;
            par_d    = parity_bit(MAX_DATA_W'(fifo_rdata), PAR_TYP);
            par_en_d = PAR_EN;
            stop2_d  = STOP2;
            presc_d  = PRESCALE;
        end
    end

    // Outputs: line level is computed from the next state so TX_OUT stays a
    // flop yet changes on the same edge as the state.
    always_comb begin
        pop  = load;
        Busy = (state_q != IDLE);
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Directed self-checking bench for uart_tx_gen2 (DATA_W=8, FIFO_DEPTH=4).
// Accepted words are queued with the frame settings expected at their pop;
// a line monitor pops them at each start bit and checks every clock of the
// frame against a bit-level model.
module tb_uart_tx_gen2;

    typedef struct {
        logic [7:0]  w;
        logic        pen;
        logic        ptyp;
        logic        st2;
        int unsigned ps;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        STOP2;
    logic [15:0] PRESCALE;
    logic        TX_OUT;
    logic        Busy;
    logic [2:0]  FIFO_LEVEL;

    uart_tx_gen2_if #(.DATA_W(8)) bus ();

    uart_tx_gen2 #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .PRESCALE_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (bus),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t        sb[$];
    logic        trace [0:255];
    int unsigned frames_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] w, input logic pen, input logic ptyp,
                                input logic st2, input int unsigned ps);
        exp_t e;
        e.w = w; e.pen = pen; e.ptyp = ptyp; e.st2 = st2; e.ps = ps;
        return e;
    endfunction

    function automatic logic exp_bit(input exp_t e, input int unsigned b);
        if (b == 0) return 1'b0;
        if (b <= 8) return e.w[b-1];
        if (e.pen && b == 9) return e.ptyp ? ~^e.w : ^e.w;
        return 1'b1;
    endfunction

    // Line monitor
    exp_t        cur;
    bit          active = 1'b0;
    int unsigned k = 0;
    int unsigned flen = 0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            active = 1'b0;
        end else if (active) begin
            check("frame_bit", TX_OUT, exp_bit(cur, k / (cur.ps + 1)));
            check("frame_busy", Busy, 1);
            k++;
            if (k == flen) begin
                active = 1'b0;
                frames_done++;
            end
        end else if (TX_OUT === 1'b0) begin
            check("start_has_expected_word", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                cur    = sb.pop_front();
                flen   = (10 + cur.pen + cur.st2) * (cur.ps + 1);
                active = 1'b1;
                k      = 0;
                check("frame_bit", TX_OUT, exp_bit(cur, 0));
                check("frame_busy", Busy, 1);
                k = 1;
            end
        end
    end

    // Called at a negedge; returns one clock later with DATA_VALID still high.
    task automatic drive_word(input logic [7:0] w, input exp_t e, output bit acc);
        bus.P_DATA     = w;
        bus.DATA_VALID = 1'b1;
        acc = (bus.DATA_READY === 1'b1);
        if (acc) sb.push_back(e);
        @(negedge clk);
    endtask

    // Bounded: waits for Busy, then records TX_OUT each clock while Busy holds.
    task automatic run_frame(input int unsigned maxc, output int unsigned n);
        int unsigned w = 0;
        n = 0;
        while (Busy !== 1'b1 && w < maxc) begin
            @(negedge clk);
            w++;
        end
        while (Busy === 1'b1 && n < maxc) begin
            trace[n] = TX_OUT;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned acc_cnt;
        int unsigned bad;
        bit          acc;
        logic [9:0]  seq;

        reset          = 1'b1;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        PAR_EN         = 1'b0;
        PAR_TYP        = 1'b0;
        STOP2          = 1'b0;
        PRESCALE       = 16'd0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", Busy, 0);
        check("rst_ready", bus.DATA_READY, 1);
        check("rst_level", FIFO_LEVEL, 0);
        reset = 1'b1;
        @(negedge clk);

        // A5, 8N1, 1 clk/bit
        drive_word(8'hA5, mk(8'hA5, 0, 0, 0, 0), acc);
        bus.DATA_VALID = 1'b0;
        check("push_level", FIFO_LEVEL, 1);
        check("push_busy", Busy, 0);
        check("push_tx", TX_OUT, 1);
        @(negedge clk);
        check("pop_busy", Busy, 1);
        check("pop_tx", TX_OUT, 0);
        check("pop_level", FIFO_LEVEL, 0);
        run_frame(64, n);
        check("a5_busy_clocks", n, 10);
        seq = '0;
        for (int i = 0; i < 10; i++) seq = {seq[8:0], trace[i]};
        check("a5_bits", seq, 10'b0101001011);
        check("a5_idle_tx", TX_OUT, 1);

        // 07, even parity, 4 clk/bit
        PRESCALE = 16'd3; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
        drive_word(8'h07, mk(8'h07, 1, 0, 0, 3), acc);
        bus.DATA_VALID = 1'b0;
        run_frame(200, n);
        check("p07_frame_clocks", n, 44);
        check("p07_parity_first", trace[36], 1);
        check("p07_parity_last", trace[39], 1);

        // 00 then FF, odd parity, two stop bits, back to back
        PRESCALE = 16'd0; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1;
        drive_word(8'h00, mk(8'h00, 1, 1, 1, 0), acc);
        drive_word(8'hFF, mk(8'hFF, 1, 1, 1, 0), acc);
        bus.DATA_VALID = 1'b0;
        run_frame(100, n);
        check("b2b_busy_clocks", n, 24);
        check("b2b_parity_00", trace[9], 1);
        check("b2b_stop2_00", trace[11], 1);
        check("b2b_second_start", trace[12], 0);
        check("b2b_parity_ff", trace[21], 1);

        // Fill the FIFO while transmitting
        PRESCALE = 16'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive_word(8'h10 + 8'(i), mk(8'h10 + 8'(i), 0, 0, 0, 0), acc);
            acc_cnt += acc;
        end
        bus.DATA_VALID = 1'b0;
        check("full_level", FIFO_LEVEL, 4);
        check("full_ready", bus.DATA_READY, 0);
        check("full_accepted", acc_cnt, 5);
        run_frame(200, n);
        check("full_remaining_busy", n, 46);
        check("full_sb_drained", sb.size(), 0);

        // Reset during DATA bit 3 of 3C with two words queued
        PRESCALE = 16'd3;
        drive_word(8'h3C, mk(8'h3C, 0, 0, 0, 3), acc);
        drive_word(8'h11, mk(8'h11, 0, 0, 0, 3), acc);
        drive_word(8'h22, mk(8'h22, 0, 0, 0, 3), acc);
        bus.DATA_VALID = 1'b0;
        repeat (16) @(negedge clk);
        check("prerst_level", FIFO_LEVEL, 2);
        check("prerst_busy", Busy, 1);
        reset = 1'b0;
        #1;
        check("midrst_tx", TX_OUT, 1);
        check("midrst_busy", Busy, 0);
        check("midrst_level", FIFO_LEVEL, 0);
        check("midrst_ready", bus.DATA_READY, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (TX_OUT !== 1'b1 || Busy !== 1'b0 || FIFO_LEVEL !== 3'd0) bad++;
        end
        check("postrst_idle_bad_clocks", bad, 0);

        // Settings changed mid-frame apply only to the next frame
        PRESCALE = 16'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        drive_word(8'h5A, mk(8'h5A, 0, 0, 0, 0), acc);
        drive_word(8'hC3, mk(8'hC3, 1, 0, 0, 7), acc);
        bus.DATA_VALID = 1'b0;
        repeat (3) @(negedge clk);
        PAR_EN   = 1'b1;
        PRESCALE = 16'd7;
        run_frame(200, n);
        check("cfg_remaining_busy", n, 95);
        check("cfg_first_stop", trace[6], 1);
        check("cfg_second_start_held", trace[14], 0);

        repeat (3) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);
        check("final_frames", frames_done, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
